// File: rtl/motor_ctrl_pkg.sv
// Shared state encoding and default tuning constants for the motor current controller.
package motor_ctrl_pkg;

    localparam int unsigned DEFAULT_PWM_BITS        = 10;
    localparam int unsigned DEFAULT_SLEW_STEP       = 8;
    localparam logic [11:0] DEFAULT_OC_LIMIT        = 12'd3000;
    localparam int unsigned DEFAULT_OC_COUNT        = 3;
    localparam logic [23:0] DEFAULT_COOLDOWN_CYCLES = 24'd1000000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFault,
        StCooldown
    } state_t;

endpackage

// File: rtl/pwm_generator.sv
// Free-running PWM counter with registered compare output and a wrap strobe
// asserted while the counter sits at its maximum value.
module pwm_generator
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                enable,
    output logic                pwm_out,
    output logic                wrap
);

    logic [PWM_BITS-1:0] cnt_q;

    assign wrap = (cnt_q == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + PWM_BITS'(1);
            pwm_out <= enable && (cnt_q < duty);
        end
    end

endmodule

// File: rtl/motor_current_control.sv
// Motor current controller: torque request to PWM duty, overcurrent trip and cooldown.
// Optional slew limiting of duty changes is enabled by defining SLEW_LIMIT_EN.
module motor_current_control
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned PWM_BITS        = DEFAULT_PWM_BITS,
    parameter int unsigned SLEW_STEP       = DEFAULT_SLEW_STEP,
    parameter logic [11:0] OC_LIMIT        = DEFAULT_OC_LIMIT,
    parameter int unsigned OC_COUNT        = DEFAULT_OC_COUNT,
    parameter logic [23:0] COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [12:0]         AssistanceRequirement,
    input  logic                brake,
    input  logic [11:0]         current_sample,
    input  logic                current_valid,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                motor_enable,
    output logic                fault
);

    localparam int unsigned OcW = $clog2(OC_COUNT + 1);

    // Without slew limiting the step bound is the full range, i.e. a direct load.
`ifdef SLEW_LIMIT_EN
    localparam logic [PWM_BITS-1:0] StepMax = PWM_BITS'(SLEW_STEP);
`else
    localparam logic [PWM_BITS-1:0] StepMax = '1;
`endif

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d, diff;
    logic [OcW-1:0]      oc_cnt_q, oc_cnt_d;
    logic [23:0]         cd_q, cd_d;
    logic [PWM_BITS-1:0] target;
    logic                wrap, oc_over, oc_trip, clear_now, cd_done, pwm_enable;
    logic                unused_req_lsbs;

    assign unused_req_lsbs = ^AssistanceRequirement[2:0];

    assign target     = brake ? '0 : AssistanceRequirement[12 -: PWM_BITS];
    assign oc_over    = current_valid && (current_sample > OC_LIMIT);
    assign oc_trip    = oc_over && (oc_cnt_q >= OcW'(OC_COUNT - 1))
                        && ((state_q == StIdle) || (state_q == StRun));
    assign clear_now  = brake || oc_trip;
    assign cd_done    = (cd_q == COOLDOWN_CYCLES - 24'd1);
    // Gate the compare in the same cycle a brake or trip is seen so the drive drops next clock.
    assign pwm_enable = (state_q == StRun) && !clear_now;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (oc_trip) state_d = StFault;
                else if (target != '0) state_d = StRun;
            end
            StRun: begin
                if (oc_trip) state_d = StFault;
                else if (wrap && (duty_q == '0) && (target == '0)) state_d = StIdle;
            end
            StFault:    state_d = StCooldown;
            StCooldown: if (cd_done && (target == '0)) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        duty_d = duty_q;
        diff   = '0;
        if ((state_q != StRun) || clear_now) begin
            duty_d = '0;
        end else if (wrap) begin
            if (target >= duty_q) begin
                diff   = target - duty_q;
                duty_d = (diff > StepMax) ? duty_q + StepMax : target;
            end else begin
                diff   = duty_q - target;
                duty_d = (diff > StepMax) ? duty_q - StepMax : target;
            end
        end
    end

    always_comb begin
        oc_cnt_d = oc_cnt_q;
        if (current_valid) begin
            if (!oc_over) oc_cnt_d = '0;
            else if (oc_cnt_q < OcW'(OC_COUNT)) oc_cnt_d = oc_cnt_q + OcW'(1);
        end
        if ((state_d == StIdle) && (state_q != StIdle)) oc_cnt_d = '0;
    end

    always_comb begin
        cd_d = '0;
        if (state_q == StCooldown) cd_d = cd_done ? cd_q : cd_q + 24'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            duty_q   <= '0;
            oc_cnt_q <= '0;
            cd_q     <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            oc_cnt_q <= oc_cnt_d;
            cd_q     <= cd_d;
        end
    end

    pwm_generator #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty   (duty_q),
        .enable (pwm_enable),
        .pwm_out(pwm_out),
        .wrap   (wrap)
    );

    assign duty         = duty_q;
    assign motor_enable = (state_q == StRun);
    assign fault        = (state_q == StFault) || (state_q == StCooldown);

endmodule

// File: tb/tb_motor_current_control.sv
// Directed self-checking bench for motor_current_control (short cooldown for run time).
module tb_motor_current_control;

    localparam int unsigned PWM_BITS = 10;

`ifdef SLEW_LIMIT_EN
    localparam int unsigned EXP_DUTY1 = 8;
    localparam int unsigned EXP_DUTY2 = 16;
`else
    localparam int unsigned EXP_DUTY1 = 512;
    localparam int unsigned EXP_DUTY2 = 512;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [12:0]         AssistanceRequirement;
    logic                brake;
    logic [11:0]         current_sample;
    logic                current_valid;
    logic                pwm_out;
    logic [PWM_BITS-1:0] duty;
    logic                motor_enable;
    logic                fault;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int high    = 0;

    always #5 clk = ~clk;

    motor_current_control #(
        .PWM_BITS       (PWM_BITS),
        .SLEW_STEP      (8),
        .OC_LIMIT       (12'd3000),
        .OC_COUNT       (3),
        .COOLDOWN_CYCLES(24'd50)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .AssistanceRequirement(AssistanceRequirement),
        .brake                (brake),
        .current_sample       (current_sample),
        .current_valid        (current_valid),
        .pwm_out              (pwm_out),
        .duty                 (duty),
        .motor_enable         (motor_enable),
        .fault                (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic step_to(input int c);
        step(c - cyc);
    endtask

    task automatic sample(input logic [11:0] v);
        current_sample = v;
        current_valid  = 1'b1;
        step(1);
        current_valid  = 1'b0;
        current_sample = 12'd0;
    endtask

    initial begin
        reset = 1'b1;
        AssistanceRequirement = 13'd0;
        brake = 1'b0;
        current_sample = 12'd0;
        current_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty", 32'(duty), 0);
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_enable", 32'(motor_enable), 0);
        check("rst_fault", 32'(fault), 0);

        // Release reset; counter starts at 0, cyc tracks edges since release.
        reset = 1'b0;
        cyc = 0;
        AssistanceRequirement = 13'd4096;
        step(1);
        check("run_enable", 32'(motor_enable), 1);
        check("run_duty_pre", 32'(duty), 0);
        step_to(1023);
        check("duty_before_wrap", 32'(duty), 0);
        step(1);
        check("duty_wrap1", 32'(duty), EXP_DUTY1);
        high = 0;
        for (int i = 0; i < 1024; i++) begin
            step(1);
            if (pwm_out) high++;
        end
        check("pwm_high_count", 32'(high), EXP_DUTY1);
        check("duty_wrap2", 32'(duty), EXP_DUTY2);

        // Brake mid-period.
        step_to(2052);
        check("pwm_before_brake", 32'(pwm_out), 1);
        brake = 1'b1;
        step(1);
        check("brake_duty", 32'(duty), 0);
        check("brake_pwm", 32'(pwm_out), 0);
        check("brake_still_run", 32'(motor_enable), 1);
        step_to(3071);
        check("brake_run_pre_wrap", 32'(motor_enable), 1);
        step(1);
        check("brake_idle_at_wrap", 32'(motor_enable), 0);

        // Overcurrent trip with invalid gaps between samples.
        brake = 1'b0;
        step(1);
        check("rerun_enable", 32'(motor_enable), 1);
        step_to(4100);
        check("rerun_duty", 32'(duty), EXP_DUTY1);
        sample(12'd3001);
        step(2);
        sample(12'd3001);
        step(1);
        check("oc_two_no_fault", 32'(fault), 0);
        sample(12'd3001);
        check("oc_fault", 32'(fault), 1);
        check("oc_pwm", 32'(pwm_out), 0);
        check("oc_duty", 32'(duty), 0);
        check("oc_enable", 32'(motor_enable), 0);

        // Cooldown held while request stays non-zero.
        step(100);
        check("cooldown_hold", 32'(fault), 1);
        AssistanceRequirement = 13'd0;
        step(1);
        check("cooldown_exit_fault", 32'(fault), 0);
        check("cooldown_exit_enable", 32'(motor_enable), 0);

        // Non-consecutive over-limit pattern, exact-limit sample, then brake + trip.
        AssistanceRequirement = 13'd4096;
        step(1);
        check("run2_enable", 32'(motor_enable), 1);
        sample(12'd3001); step(1);
        sample(12'd3001); step(1);
        sample(12'd2999); step(1);
        sample(12'd3001); step(1);
        check("pattern_no_fault", 32'(fault), 0);
        sample(12'd3000); step(1);
        sample(12'd3001); step(1);
        sample(12'd3001); step(1);
        check("limit_clears_count", 32'(fault), 0);
        check("still_run", 32'(motor_enable), 1);
        brake = 1'b1;
        sample(12'd3001);
        check("brake_and_trip_fault", 32'(fault), 1);
        brake = 1'b0;

        // Reset in the middle of cooldown.
        step(10);
        check("mid_cooldown_fault", 32'(fault), 1);
        reset = 1'b1;
        #1;
        check("cd_rst_fault", 32'(fault), 0);
        check("cd_rst_enable", 32'(motor_enable), 0);
        check("cd_rst_duty", 32'(duty), 0);
        check("cd_rst_pwm", 32'(pwm_out), 0);
        step(2);
        reset = 1'b0;
        AssistanceRequirement = 13'd0;
        step(5);
        check("post_rst_idle", 32'(motor_enable), 0);
        check("post_rst_no_fault", 32'(fault), 0);
        AssistanceRequirement = 13'd4096;
        step(1);
        check("post_rst_run", 32'(motor_enable), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
